// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load-use/branch/memory-wait
// stall and flush control, memory timeout detection and stall statistics.
module hazard_ctrl #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] rs1_d,
  input  logic [REG_ADDR_W-1:0] rs2_d,
  input  logic [REG_ADDR_W-1:0] rs1_e,
  input  logic [REG_ADDR_W-1:0] rs2_e,
  input  logic [REG_ADDR_W-1:0] rd_e,
  input  logic                  mem_read_e,
  input  logic                  pc_src_e,
  input  logic [REG_ADDR_W-1:0] rd_m,
  input  logic                  reg_write_m,
  input  logic [REG_ADDR_W-1:0] rd_w,
  input  logic                  reg_write_w,
  input  logic                  dmem_req_m,
  input  logic                  dmem_ready,
  output logic [1:0]            fwd_a_e,
  output logic [1:0]            fwd_b_e,
  output logic                  stall_f,
  output logic                  stall_d,
  output logic                  stall_e,
  output logic                  stall_m,
  output logic                  flush_d,
  output logic                  flush_e,
  output logic                  flush_w,
  output logic                  err_timeout,
  output logic [15:0]           stall_cnt
);

  localparam int unsigned WAIT_W = 8;
  localparam int unsigned CNT_W  = 16;

  localparam logic [1:0] RUN      = 2'd0;
  localparam logic [1:0] MEM_WAIT = 2'd1;
  localparam logic [1:0] ERROR    = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [WAIT_W-1:0] wait_nxt;
  logic              mem_stall;
  logic              load_use;

  assign mem_stall = dmem_req_m & ~dmem_ready;
  assign load_use  = mem_read_e & (rd_e != '0) & ((rd_e == rs1_d) | (rd_e == rs2_d));

  // State, wait counter and saturating stall statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      wait_cnt  <= '0;
      stall_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
      if (stall_f && (stall_cnt != '1)) begin
        stall_cnt <= stall_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state: count consecutive memory-stall cycles until timeout
  always_comb begin
    state_nxt = state;
    wait_nxt  = wait_cnt;
    case (state)
      RUN: begin
        if (mem_stall) begin
          state_nxt = MEM_WAIT;
          wait_nxt  = WAIT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (!mem_stall) begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end else if (wait_cnt == WAIT_W'(TIMEOUT - 1)) begin
          state_nxt = ERROR;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      ERROR: begin
        state_nxt = ERROR;
      end
      default: begin
        state_nxt = RUN;
        wait_nxt  = '0;
      end
    endcase
  end

  // Stall/flush priority: error, memory wait, branch, load-use
  always_comb begin
    stall_f     = 1'b0;
    stall_d     = 1'b0;
    stall_e     = 1'b0;
    stall_m     = 1'b0;
    flush_d     = 1'b0;
    flush_e     = 1'b0;
    flush_w     = 1'b0;
    err_timeout = 1'b0;
    if (state == ERROR) begin
      stall_f     = 1'b1;
      stall_d     = 1'b1;
      stall_e     = 1'b1;
      stall_m     = 1'b1;
      flush_w     = 1'b1;
      err_timeout = 1'b1;
    end else if (mem_stall) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      stall_e = 1'b1;
      stall_m = 1'b1;
      flush_w = 1'b1;
    end else if (pc_src_e) begin
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (load_use) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // Operand forwarding, memory stage has priority; x0 is never forwarded
  always_comb begin
    fwd_a_e = 2'b00;
    fwd_b_e = 2'b00;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs1_e)) begin
      fwd_a_e = 2'b10;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs1_e)) begin
      fwd_a_e = 2'b01;
    end
    if (reg_write_m && (rd_m != '0) && (rd_m == rs2_e)) begin
      fwd_b_e = 2'b10;
    end else if (reg_write_w && (rd_w != '0) && (rd_w == rs2_e)) begin
      fwd_b_e = 2'b01;
    end
  end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 The block SHALL have parameter REG_ADDR_W, default 5, meaning register-index width.
REQ-002 The block SHALL have parameter TIMEOUT, default 16, meaning consecutive memory-stall cycles before the error state (legal range 2..255).
REQ-003 The block SHALL have these ports:
- clk  in  1  pipeline clock, all state on rising edge
- rst  in  1  reset, synchronous, active-high
- rs1_d, rs2_d  in  REG_ADDR_W  decode-stage source registers
- rs1_e, rs2_e  in  REG_ADDR_W  execute-stage source registers
- rd_e  in  REG_ADDR_W  execute-stage destination
- mem_read_e  in  1  execute-stage instruction is a load
- pc_src_e  in  1  execute-stage branch/jump taken
- rd_m, reg_write_m  in  REG_ADDR_W, 1  memory-stage destination and write enable
- rd_w, reg_write_w  in  REG_ADDR_W, 1  writeback-stage destination and write enable
- dmem_req_m  in  1  memory-stage data-memory access valid
- dmem_ready  in  1  data memory completes access this cycle
- fwd_a_e, fwd_b_e  out  2  operand forward selects: 00 register file, 01 writeback result, 10 memory-stage ALU result; 11 never driven
- stall_f, stall_d, stall_e, stall_m  out  1  hold the corresponding pipeline register
- flush_d, flush_e, flush_w  out  1  load a bubble into the corresponding pipeline register
- err_timeout  out  1  sticky memory-timeout flag
- stall_cnt  out  16  saturating count of cycles with stall_f asserted

Function
REQ-004 fwd_a_e SHALL be 10 when reg_write_m, rd_m != 0 and rd_m == rs1_e; else 01 when reg_write_w, rd_w != 0 and rd_w == rs1_e; else 00. fwd_b_e SHALL use the same rule with rs2_e.
REQ-005 Forwarding SHALL be combinational, SHALL be valid in every state, and SHALL NOT forward register 0.
REQ-006 mem_stall SHALL be defined as dmem_req_m AND NOT dmem_ready.
REQ-007 load_use SHALL be defined as mem_read_e AND rd_e != 0 AND (rd_e == rs1_d OR rd_e == rs2_d).
REQ-008 The FSM SHALL have the states RUN, MEM_WAIT and ERROR.
REQ-009 FSM transitions SHALL be:
- RUN -> MEM_WAIT on mem_stall, with wait_cnt set to 1.
- MEM_WAIT -> RUN on NOT mem_stall, with wait_cnt cleared.
- MEM_WAIT -> ERROR on mem_stall when wait_cnt == TIMEOUT-1.
- MEM_WAIT stays in MEM_WAIT on mem_stall otherwise, with wait_cnt incremented.
- ERROR stays in ERROR until rst.
REQ-010 Control outputs in RUN and MEM_WAIT SHALL be set by the first matching priority, all unlisted controls 0:
- (a) mem_stall: stall_f, stall_d, stall_e, stall_m and flush_w = 1.
- (b) pc_src_e: flush_d and flush_e = 1. A branch overrides load_use; no stall is applied.
- (c) load_use: stall_f, stall_d and flush_e = 1, for exactly one cycle per hazard.
- (d) otherwise all controls = 0.
REQ-011 In ERROR, stall_f, stall_d, stall_e, stall_m, flush_w and err_timeout SHALL all be 1, and all other flushes 0, regardless of inputs.
REQ-012 Control outputs SHALL be combinational from inputs and registered state; the added latency SHALL be 0 cycles.
REQ-013 stall_cnt SHALL increment by 1 on each rising edge where stall_f = 1, and SHALL saturate at 0xFFFF without wrapping.
REQ-014 In the dmem_ready cycle that ends a MEM_WAIT, outputs SHALL follow rules (b) to (d) in the same cycle.

Reset
REQ-015 While rst = 1, on the clock edge the block SHALL set state to RUN, wait_cnt to 0, stall_cnt to 0 and err_timeout to 0.
REQ-016 rst SHALL override every state, including ERROR and MEM_WAIT mid-stall.
REQ-017 Combinational outputs SHALL follow REQ-010 from the first cycle after reset.

Verification
REQ-018 Forwarding scenarios:
- rd_m = rd_w = rs1_e = 5, both write enables 1 -> fwd_a_e = 10.
- reg_write_m = 0 -> fwd_a_e = 01.
- rs1_e = 0 with matching rd = 0 -> fwd_a_e = 00.
REQ-019 Load-use scenario: mem_read_e = 1, rd_e = 3, rs2_d = 3 for one cycle -> stall_f = stall_d = flush_e = 1 for that cycle only; stall_cnt goes 0 -> 1.
REQ-020 Branch-versus-load-use scenario: load_use and pc_src_e = 1 together -> flush_d = flush_e = 1 and stall_f = 0.
REQ-021 Memory-wait scenario: dmem_req_m = 1 with dmem_ready low for 3 cycles, then high -> four stalls and flush_w = 1 for 3 cycles, then normal outputs; stall_cnt = 3; err_timeout stays 0.
REQ-022 Timeout scenario: dmem_ready held low for 16 cycles (TIMEOUT = 16) -> ERROR entered; err_timeout = 1 and stalls persist after dmem_ready rises; rst = 1 for one cycle returns to RUN with all counters 0.
REQ-023 Saturation scenario: stall_f held high for 70000 cycles -> stall_cnt = 0xFFFF and holds.
